// File: rtl/branch_update_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_update_queue
// Brief    : In-order queue of predicted branches; resolves the head entry,
//            issues a registered PHT update and flags mispredictions.
// Revision : 1.0
// ============================================================================
module branch_update_queue #(
    parameter int NUM_ENTRIES = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pred_val,
    output logic                               pred_rdy,
    input  logic [31:0]                        pred_pc,
    input  logic                               pred_taken,
    input  logic                               resolve_val,
    output logic                               resolve_rdy,
    input  logic                               resolve_taken,
    input  logic                               squash,
    output logic                               mispredict,
    output logic                               upd_val,
    output logic [31:0]                        upd_pc,
    output logic                               upd_taken,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   count,
    output logic [31:0]                        num_mispred
);

    localparam int c_PTR_W = $clog2(NUM_ENTRIES);
    localparam int c_CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(NUM_ENTRIES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [31:0]        r_pc_mem    [NUM_ENTRIES];
    logic               r_taken_mem [NUM_ENTRIES];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               r_upd_val;
    logic [31:0]        r_upd_pc;
    logic               r_upd_taken;
    logic [31:0]        r_num_mispred;

    logic               w_enq_fire;
    logic               w_deq_fire;
    logic               w_mispredict;
    logic [c_PTR_W-1:0] w_head_adv;
    logic [c_CNT_W-1:0] w_count_next;

    assign pred_rdy     = (r_count != c_FULL);
    assign resolve_rdy  = (r_count != '0);
    assign w_enq_fire   = pred_val && pred_rdy;
    assign w_deq_fire   = resolve_val && resolve_rdy;
    assign w_mispredict = w_deq_fire && (resolve_taken != r_taken_mem[r_head]);
    assign w_head_adv   = w_deq_fire ? (r_head + c_PTR_ONE) : r_head;

    always_comb begin
        w_count_next = r_count;
        case ({w_enq_fire, w_deq_fire})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Entry payload needs no reset; validity is tracked by head/tail/count.
    always_ff @(posedge clk) begin
        if (w_enq_fire && !squash) begin
            r_pc_mem[r_tail]    <= pred_pc;
            r_taken_mem[r_tail] <= pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head <= w_head_adv;
            // Squash lets a same-cycle resolve complete, then empties the queue.
            if (squash) begin
                r_tail  <= w_head_adv;
                r_count <= '0;
            end else begin
                if (w_enq_fire) begin
                    r_tail <= r_tail + c_PTR_ONE;
                end
                r_count <= w_count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_upd_val     <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_taken   <= 1'b0;
            r_num_mispred <= '0;
        end else begin
            r_upd_val <= w_deq_fire;
            if (w_deq_fire) begin
                r_upd_pc    <= r_pc_mem[r_head];
                r_upd_taken <= resolve_taken;
            end
            if (w_mispredict) begin
                r_num_mispred <= r_num_mispred + 32'd1;
            end
        end
    end

    assign mispredict  = w_mispredict;
    assign upd_val     = r_upd_val;
    assign upd_pc      = r_upd_pc;
    assign upd_taken   = r_upd_taken;
    assign count       = r_count;
    assign num_mispred = r_num_mispred;

endmodule
`default_nettype wire
